// File: rtl/ysyx_25020037_wbu_pkg.sv
// Shared widths, write-back select codes, load funct3 codes and the LSU->WBU bus layout.
package ysyx_25020037_wbu_pkg;

  localparam int LU_TO_WU_BUS_WD = 173;
  localparam int WU_TO_GU_BUS_WD = 33;

  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_LD  = 2'b01;
  localparam logic [1:0] WB_SEL_CSR = 2'b10;
  localparam logic [1:0] WB_SEL_PC4 = 2'b11;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] dnpc;
    logic [31:0] alu_res;
    logic [31:0] ld_rdata;
    logic [31:0] csr_rdata;
    logic [4:0]  rd;
    logic        rf_we;
    logic [1:0]  wb_sel;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_addr_lo;
  } lu_to_wu_t;

  // x0 is hardwired, so a write to it is never enabled.
  function automatic logic wb_wen(input logic rf_we, input logic [4:0] rd);
    return rf_we & (rd != 5'd0);
  endfunction

endpackage

// File: rtl/ysyx_25020037_wbu_if.sv
// LSU->WBU capture handshake, WBU->GPR write-back handshake and commit signals.
interface ysyx_25020037_wbu_if;
  import ysyx_25020037_wbu_pkg::*;

  logic                       lsu_valid;
  logic                       wbu_ready;
  logic [LU_TO_WU_BUS_WD-1:0] lu_to_wu_bus;
  logic                       wbu_valid;
  logic                       gpr_ready;
  logic                       gpr_we;
  logic [4:0]                 wbu_rd;
  logic [WU_TO_GU_BUS_WD-1:0] wu_to_gu_bus;
  logic                       wbu_commit;
  logic [31:0]                commit_pc;
  logic [31:0]                commit_dnpc;

  modport master (
    input  lsu_valid, lu_to_wu_bus, gpr_ready,
    output wbu_ready, wbu_valid, gpr_we, wbu_rd, wu_to_gu_bus,
           wbu_commit, commit_pc, commit_dnpc
  );

  modport slave (
    output lsu_valid, lu_to_wu_bus, gpr_ready,
    input  wbu_ready, wbu_valid, gpr_we, wbu_rd, wu_to_gu_bus,
           wbu_commit, commit_pc, commit_dnpc
  );

endinterface

// File: rtl/ysyx_25020037_Reg.sv
// Generic enable-loaded register with asynchronous active-low reset to RESET_VAL.
module ysyx_25020037_Reg #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wen,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= RESET_VAL;
    end else if (i_wen) begin
      r_q <= i_din;
    end
  end

  assign o_dout = r_q;

endmodule

// File: rtl/ysyx_25020037_wbu_ldext.sv
// Combinational load extender: picks byte/half by address low bits, then sign/zero-extends by funct3.
module ysyx_25020037_ldext
  import ysyx_25020037_wbu_pkg::*;
(
  input  logic [31:0] i_ld_rdata,
  input  logic [1:0]  i_ld_addr_lo,
  input  logic [2:0]  i_ld_funct3,
  output logic [31:0] o_ld_res
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_ld_rdata[7:0];
    case (i_ld_addr_lo)
      2'd1:    w_byte = i_ld_rdata[15:8];
      2'd2:    w_byte = i_ld_rdata[23:16];
      2'd3:    w_byte = i_ld_rdata[31:24];
      default: w_byte = i_ld_rdata[7:0];
    endcase
  end

  // Halfword selection ignores addr bit 0; misaligned halves are not split.
  assign w_half = i_ld_addr_lo[1] ? i_ld_rdata[31:16] : i_ld_rdata[15:0];

  always_comb begin
    o_ld_res = i_ld_rdata;
    case (i_ld_funct3)
      F3_LB:   o_ld_res = {{24{w_byte[7]}}, w_byte};
      F3_LH:   o_ld_res = {{16{w_half[15]}}, w_half};
      F3_LW:   o_ld_res = i_ld_rdata;
      F3_LBU:  o_ld_res = {24'd0, w_byte};
      F3_LHU:  o_ld_res = {16'd0, w_half};
      default: o_ld_res = i_ld_rdata;
    endcase
  end

endmodule

// File: rtl/ysyx_25020037_wbu.sv
// Write-back unit: capture one retired instr, hold {gpr_wen,gpr_wdata} until GPR accepts, then pulse commit.
// Optional 64-bit retire counter and retire_cnt port under YSYX_25020037_WBU_RETIRE_CNT_EN.
module ysyx_25020037_wbu
  import ysyx_25020037_wbu_pkg::*;
#(
  parameter logic [31:0] RST_PC = 32'h8000_0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ysyx_25020037_wbu_if.master  io
`ifdef YSYX_25020037_WBU_RETIRE_CNT_EN
  ,
  output logic [63:0]          retire_cnt
`endif
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  logic [0:0]                 r_state;
  logic                       w_cap;
  logic                       w_acc;
  logic [LU_TO_WU_BUS_WD-1:0] w_bus_q;
  lu_to_wu_t                  w_lu;
  logic [31:0]                w_ld_res;
  logic [31:0]                w_wdata;
  logic                       w_wen;
  logic                       r_commit;
  logic [31:0]                r_commit_pc;
  logic [31:0]                r_commit_dnpc;

  assign w_cap = (r_state == S_IDLE) & io.lsu_valid;
  assign w_acc = (r_state == S_HOLD) & io.gpr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else if (w_cap) begin
      r_state <= S_HOLD;
    end else if (w_acc) begin
      r_state <= S_IDLE;
    end
  end

  ysyx_25020037_Reg #(
    .WIDTH     (LU_TO_WU_BUS_WD),
    .RESET_VAL ('0)
  ) u_bus_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_wen  (w_cap),
    .i_din  (io.lu_to_wu_bus),
    .o_dout (w_bus_q)
  );

  assign w_lu = lu_to_wu_t'(w_bus_q);

  ysyx_25020037_ldext u_ldext (
    .i_ld_rdata   (w_lu.ld_rdata),
    .i_ld_addr_lo (w_lu.ld_addr_lo),
    .i_ld_funct3  (w_lu.ld_funct3),
    .o_ld_res     (w_ld_res)
  );

  always_comb begin
    w_wdata = w_lu.alu_res;
    case (w_lu.wb_sel)
      WB_SEL_LD:  w_wdata = w_ld_res;
      WB_SEL_CSR: w_wdata = w_lu.csr_rdata;
      WB_SEL_PC4: w_wdata = w_lu.pc + 32'd4;
      default:    w_wdata = w_lu.alu_res;
    endcase
  end

  assign w_wen = wb_wen(w_lu.rf_we, w_lu.rd);

  // All payload outputs come from the capture register, never from the live LSU bus.
  assign io.wbu_ready    = (r_state == S_IDLE);
  assign io.wbu_valid    = (r_state == S_HOLD);
  assign io.gpr_we       = w_wen;
  assign io.wbu_rd       = w_lu.rd;
  assign io.wu_to_gu_bus = {w_wen, w_wdata};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_commit      <= 1'b0;
      r_commit_pc   <= RST_PC;
      r_commit_dnpc <= RST_PC;
    end else begin
      r_commit <= w_acc;
      if (w_acc) begin
        r_commit_pc   <= w_lu.pc;
        r_commit_dnpc <= w_lu.dnpc;
      end
    end
  end

  assign io.wbu_commit  = r_commit;
  assign io.commit_pc   = r_commit_pc;
  assign io.commit_dnpc = r_commit_dnpc;

`ifdef YSYX_25020037_WBU_RETIRE_CNT_EN
  logic [63:0] r_retire_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retire_cnt <= 64'd0;
    end else if (w_acc) begin
      r_retire_cnt <= r_retire_cnt + 64'd1;
    end
  end

  assign retire_cnt = r_retire_cnt;
`endif

endmodule

// File: tb/tb_ysyx_25020037_wbu.sv
// Bench for ysyx_25020037_wbu: transaction-level model plus directed vectors with literal expectations.
module tb_ysyx_25020037_wbu;
  import ysyx_25020037_wbu_pkg::*;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  ysyx_25020037_wbu_if io ();
`ifdef YSYX_25020037_WBU_RETIRE_CNT_EN
  logic [63:0] retire_cnt;
`endif

  ysyx_25020037_wbu #(.RST_PC(RST_PC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
`ifdef YSYX_25020037_WBU_RETIRE_CNT_EN
    ,
    .retire_cnt (retire_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected {gpr_wen, gpr_wdata} from the field values using plain shifts and arithmetic.
  function automatic logic [32:0] exp_wb(input lu_to_wu_t t);
    logic [31:0] b, h, d;
    b = (t.ld_rdata >> (8 * t.ld_addr_lo)) & 32'hFF;
    h = (t.ld_rdata >> (16 * t.ld_addr_lo[1])) & 32'hFFFF;
    case (t.wb_sel)
      2'd0: d = t.alu_res;
      2'd2: d = t.csr_rdata;
      2'd3: d = t.pc + 32'd4;
      default: begin
        case (t.ld_funct3)
          3'd0:    d = (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
          3'd1:    d = (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
          3'd4:    d = b;
          3'd5:    d = h;
          default: d = t.ld_rdata;
        endcase
      end
    endcase
    return {(t.rf_we && t.rd != 5'd0), d};
  endfunction

  // Model state: one outstanding instruction, last committed PCs, retire count.
  bit          m_busy   = 1'b0;
  lu_to_wu_t   m_txn    = '0;
  bit          m_commit = 1'b0;
  logic [31:0] m_cpc    = RST_PC;
  logic [31:0] m_cdnpc  = RST_PC;
  logic [63:0] m_cnt    = 64'd0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_commit = 1'b0; m_txn = '0;
      m_cpc = RST_PC; m_cdnpc = RST_PC; m_cnt = 64'd0;
    end else begin
      m_commit = 1'b0;
      if (m_busy) begin
        if (io.gpr_ready) begin
          m_busy = 1'b0; m_commit = 1'b1;
          m_cpc = m_txn.pc; m_cdnpc = m_txn.dnpc; m_cnt = m_cnt + 64'd1;
        end
      end else if (io.lsu_valid) begin
        m_busy = 1'b1;
        m_txn  = io.lu_to_wu_bus;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_ready",  io.wbu_ready,   !m_busy);
      check("m_valid",  io.wbu_valid,   m_busy);
      check("m_commit", io.wbu_commit,  m_commit);
      check("m_cpc",    io.commit_pc,   m_cpc);
      check("m_cdnpc",  io.commit_dnpc, m_cdnpc);
      if (m_busy) begin
        check("m_bus", io.wu_to_gu_bus, exp_wb(m_txn));
        check("m_we",  io.gpr_we,       exp_wb(m_txn) >> 32);
        check("m_rd",  io.wbu_rd,       m_txn.rd);
      end
`ifdef YSYX_25020037_WBU_RETIRE_CNT_EN
      check("m_cnt", retire_cnt, m_cnt);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic lu_to_wu_t mk(input logic [31:0] pc, input logic [31:0] alu,
                                   input logic [31:0] ldr, input logic [31:0] csr,
                                   input logic [4:0] rd, input logic we, input logic [1:0] sel,
                                   input logic [2:0] f3, input logic [1:0] lo);
    lu_to_wu_t t;
    t.pc = pc; t.dnpc = pc + 32'd4; t.alu_res = alu; t.ld_rdata = ldr; t.csr_rdata = csr;
    t.rd = rd; t.rf_we = we; t.wb_sel = sel; t.ld_funct3 = f3; t.ld_addr_lo = lo;
    return t;
  endfunction

  task automatic issue(input lu_to_wu_t t, input int stall, input logic [32:0] lit);
    io.lu_to_wu_bus = t;
    io.lsu_valid    = 1'b1;
    io.gpr_ready    = (stall == 0);
    step();
    io.lsu_valid = 1'b0;
    check("hold_valid", io.wbu_valid, 1'b1);
    check("hold_bus",   io.wu_to_gu_bus, lit);
    for (int i = 0; i < stall; i++) begin
      io.lsu_valid    = 1'b1;
      io.lu_to_wu_bus = ~t;
      io.gpr_ready    = 1'b0;
      step();
      check("stall_nocommit", io.wbu_commit, 1'b0);
      check("stall_bus",      io.wu_to_gu_bus, lit);
    end
    io.lsu_valid = 1'b0;
    io.gpr_ready = 1'b1;
    step();
    io.gpr_ready = 1'b0;
    check("commit_pulse", io.wbu_commit, 1'b1);
    check("commit_pc",    io.commit_pc,  t.pc);
    step();
    check("commit_drop",  io.wbu_commit, 1'b0);
  endtask

  localparam logic [31:0] LDR = 32'h80FF_7F01;

  initial begin
    io.lsu_valid    = 1'b0;
    io.gpr_ready    = 1'b0;
    io.lu_to_wu_bus = '0;
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready",  io.wbu_ready,    1'b1);
    check("rst_valid",  io.wbu_valid,    1'b0);
    check("rst_bus",    io.wu_to_gu_bus, 33'h0);
    check("rst_rd",     io.wbu_rd,       5'd0);
    check("rst_pc",     io.commit_pc,    32'h8000_0000);
    check("rst_dnpc",   io.commit_dnpc,  32'h8000_0000);
    rst_n = 1'b1;
    step();
    check("idle_ready", io.wbu_ready, 1'b1);

    issue(mk(32'h8000_0000, 32'h0, LDR, 32'h0, 5'd5,  1'b1, 2'b01, 3'b000, 2'd3), 0, 33'h1_FFFF_FF80);
    issue(mk(32'h8000_0004, 32'h0, LDR, 32'h0, 5'd5,  1'b1, 2'b01, 3'b101, 2'd2), 0, 33'h1_0000_80FF);
    issue(mk(32'h8000_0008, 32'h0, LDR, 32'h0, 5'd6,  1'b1, 2'b01, 3'b001, 2'd3), 0, 33'h1_FFFF_80FF);
    issue(mk(32'h8000_000C, 32'h0, LDR, 32'h0, 5'd7,  1'b1, 2'b01, 3'b111, 2'd1), 0, 33'h1_80FF_7F01);
    issue(mk(32'h8000_0010, 32'h0, LDR, 32'h0, 5'd8,  1'b1, 2'b01, 3'b100, 2'd1), 0, 33'h1_0000_007F);
    issue(mk(32'h8000_0014, 32'h1234_5678, LDR, 32'h0, 5'd10, 1'b1, 2'b00, 3'b000, 2'd0), 0, 33'h1_1234_5678);
    issue(mk(32'h8000_0018, 32'h0, LDR, 32'hDEAD_BEEF, 5'd31, 1'b1, 2'b10, 3'b000, 2'd0), 4, 33'h1_DEAD_BEEF);
    issue(mk(32'hFFFF_FFFC, 32'h0, LDR, 32'h0, 5'd0,  1'b1, 2'b11, 3'b000, 2'd0), 0, 33'h0_0000_0000);
    issue(mk(32'h8000_0010, 32'h0, LDR, 32'h0, 5'd1,  1'b1, 2'b11, 3'b000, 2'd0), 0, 33'h1_8000_0014);
    issue(mk(32'h8000_0020, 32'h5, LDR, 32'h0, 5'd3,  1'b0, 2'b00, 3'b000, 2'd0), 0, 33'h0_0000_0005);

    // Reset while holding: the captured instruction must vanish without committing.
    io.lu_to_wu_bus = mk(32'h8000_0100, 32'h9, LDR, 32'h0, 5'd4, 1'b1, 2'b00, 3'b000, 2'd0);
    io.lsu_valid    = 1'b1;
    io.gpr_ready    = 1'b0;
    step();
    io.lsu_valid = 1'b0;
    check("pre_rst_valid", io.wbu_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", io.wbu_valid,    1'b0);
    check("mid_rst_ready", io.wbu_ready,    1'b1);
    check("mid_rst_bus",   io.wu_to_gu_bus, 33'h0);
    check("mid_rst_pc",    io.commit_pc,    RST_PC);
    io.gpr_ready = 1'b1;
    step();
    check("mid_rst_nocommit", io.wbu_commit, 1'b0);
    rst_n = 1'b1;
    step();
    check("post_rst_nocommit", io.wbu_commit, 1'b0);
    io.gpr_ready = 1'b0;

    for (int k = 0; k < 3; k++) begin
      issue(mk(32'h8000_0200 + 32'(k * 4), 32'(k), LDR, 32'h0, 5'd9, 1'b1, 2'b00, 3'b000, 2'd0),
            k, {1'b1, 32'(k)});
    end
`ifdef YSYX_25020037_WBU_RETIRE_CNT_EN
    check("retire_cnt_3", retire_cnt, 64'd3);
`endif
    check("final_dnpc", io.commit_dnpc, 32'h8000_020C);

    step();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
